// File: rtl/pipe_pkg.sv
// Shared pipeline types: stage control encoding, stage bundles and
// the per-stage control decision used by pipe_stage_chain.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_HOLD,
        ST_BUBBLE,
        ST_KILL
    } stage_ctl_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [3:0]  alu_op;
    } id_ex_t;

    // s/f are the highest stalled/flushed stage, -1 when none.
    function automatic stage_ctl_e stage_ctl(
        input int   k,
        input int   s,
        input int   f,
        input logic en
    );
        stage_ctl_e c;
        c = ST_LOAD;
        if (f >= 0 && k <= f)
            c = ST_KILL;
        else if (!en)
            c = ST_HOLD;
        else if (f >= 0 && s <= f && k == f + 1)
            c = ST_BUBBLE;
        else if (s > f && k <= s)
            c = ST_HOLD;
        else if (s > f && k == s + 1)
            c = ST_BUBBLE;
        return c;
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline register slice: payload plus valid bit,
// steered by a stage_ctl_e command.
module pipe_stage
    import pipe_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int CLR_ON_BUBBLE = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  stage_ctl_e       ctl,
    input  logic             prev_valid,
    input  logic [WIDTH-1:0] prev_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            unique case (ctl)
                ST_LOAD: begin
                    valid <= prev_valid;
                    data  <= prev_data;
                end
                ST_HOLD: begin
                    valid <= valid;
                    data  <= data;
                end
                ST_BUBBLE, ST_KILL: begin
                    valid <= 1'b0;
                    if (CLR_ON_BUBBLE != 0)
                        data <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_stage_chain.sv
// NSTAGE-deep pipeline latch chain with per-stage stall/flush.
// Define PIPE_PERF_EN to build the saturating stall/flush counters.
module pipe_stage_chain
    import pipe_pkg::*;
#(
    parameter int WIDTH         = 32,
    parameter int NSTAGE        = 4,
    parameter int CLR_ON_BUBBLE = 1,
    parameter int CNT_W         = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    en,
    input  logic                    in_valid,
    input  logic [WIDTH-1:0]        in_data,
    output logic                    in_ready,
    input  logic [NSTAGE-1:0]       stall_req,
    input  logic [NSTAGE-1:0]       flush_req,
    output logic [NSTAGE-1:0]       stage_valid,
    output logic [NSTAGE*WIDTH-1:0] stage_data,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [CNT_W-1:0]        stall_cnt,
    output logic [CNT_W-1:0]        flush_cnt
);

    int s_idx;
    int f_idx;

    logic [NSTAGE-1:0]            v;
    logic [NSTAGE-1:0][WIDTH-1:0] d;

    always_comb begin
        s_idx = -1;
        f_idx = -1;
        for (int k = 0; k < NSTAGE; k++) begin
            if (stall_req[k])
                s_idx = k;
            if (flush_req[k])
                f_idx = k;
        end
    end

    assign in_ready = en & ~|stall_req & ~|flush_req;

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        stage_ctl_e       ctl;
        logic             pv;
        logic [WIDTH-1:0] pd;

        assign ctl = stage_ctl(k, s_idx, f_idx, en);

        if (k == 0) begin : g_head
            assign pv = in_valid;
            assign pd = in_data;
        end else begin : g_body
            assign pv = v[k-1];
            assign pd = d[k-1];
        end

        pipe_stage #(
            .WIDTH         (WIDTH),
            .CLR_ON_BUBBLE (CLR_ON_BUBBLE)
        ) u_stage (
            .CLK        (CLK),
            .RST        (RST),
            .ctl        (ctl),
            .prev_valid (pv),
            .prev_data  (pd),
            .valid      (v[k]),
            .data       (d[k])
        );
    end

    assign stage_valid = v;
    assign stage_data  = d;
    assign out_valid   = v[NSTAGE-1];
    assign out_data    = d[NSTAGE-1];

`ifdef PIPE_PERF_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    // Saturate rather than wrap so long stalls never read as short ones.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (en && |stall_req && stall_q != '1)
                stall_q <= stall_q + 1'b1;
            if (|flush_req && flush_q != '1)
                flush_q <= flush_q + 1'b1;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
